// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// Optional macro PREFIX_ADDER_PIPE_OVF_EN adds the signed-overflow output out_ovf.
module prefix_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef PREFIX_ADDER_PIPE_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int LEVELS  = $clog2(WIDTH);
    localparam int STEP    = (LEVELS + STAGES) / (STAGES + 1);
    localparam int PLACED  = (STAGES < LEVELS / STEP) ? STAGES : LEVELS / STEP;
    localparam int SURPLUS = STAGES - PLACED;
    // Stage bundle layout: {valid, c0, half-sum, group P, group G}
    localparam int BW      = 3 * WIDTH + 2;

    logic adv_s;
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    logic             in_v_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c0_r;

    // Input register: B is conditioned and the carry-in adjusted for subtract on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_v_r <= 1'b0;
        end else if (adv_s) begin
            in_v_r <= in_valid;
        end
        if (adv_s && in_valid) begin
            a_r  <= in_a;
            b_r  <= in_sub ? ~in_b : in_b;
            c0_r <= in_cin ^ in_sub;
        end
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam bit REG = (l > 0) && (l % STEP == 0) && (l / STEP <= STAGES);
        logic [WIDTH-1:0] g_s;
        logic [WIDTH-1:0] p_s;
        logic [WIDTH-1:0] hp_s;
        logic             c0_s;
        logic             v_s;
        logic [BW-1:0]    d_s;
        logic [BW-1:0]    q_s;

        if (l == 0) begin : g_pre
            assign hp_s = a_r ^ b_r;
            assign p_s  = hp_s;
            // Carry-in folded into bit 0 so group generates become carries directly.
            assign g_s  = (a_r & b_r) | {{(WIDTH-1){1'b0}}, hp_s[0] & c0_r};
            assign c0_s = c0_r;
            assign v_s  = in_v_r;
        end else begin : g_ks
            localparam int D = 2 ** (l - 1);
            logic [WIDTH-1:0] g_p;
            logic [WIDTH-1:0] p_p;
            assign {v_s, c0_s, hp_s, p_p, g_p} = g_lvl[l-1].q_s;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i >= D) begin : g_cell
                    assign g_s[i] = g_p[i] | (p_p[i] & g_p[i-D]);
                    assign p_s[i] = p_p[i] & p_p[i-D];
                end else begin : g_pass
                    assign g_s[i] = g_p[i];
                    assign p_s[i] = p_p[i];
                end
            end
        end

        assign d_s = {v_s, c0_s, hp_s, p_s, g_s};

        if (REG) begin : g_reg
            // Prefix stage register: shifts on adv, only the valid bit is reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_s[BW-1] <= 1'b0;
                end else if (adv_s) begin
                    q_s[BW-1] <= d_s[BW-1];
                end
                if (adv_s && d_s[BW-1]) begin
                    q_s[BW-2:0] <= d_s[BW-2:0];
                end
            end
        end else begin : g_wire
            assign q_s = d_s;
        end
    end

    // Registers that do not fit the even spacing stack up after the last level.
    for (genvar s = 0; s <= SURPLUS; s++) begin : g_sur
        logic [BW-1:0] q_s;
        if (s == 0) begin : g_tap
            assign q_s = g_lvl[LEVELS].q_s;
        end else begin : g_reg
            // Surplus stage register, same shift/hold rules as the in-network ones.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_s[BW-1] <= 1'b0;
                end else if (adv_s) begin
                    q_s[BW-1] <= g_sur[s-1].q_s[BW-1];
                end
                if (adv_s && g_sur[s-1].q_s[BW-1]) begin
                    q_s[BW-2:0] <= g_sur[s-1].q_s[BW-2:0];
                end
            end
        end
    end

    logic [BW-1:0]    fin_s;
    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] sum_s;
    logic             unused_s;
    assign fin_s    = g_sur[SURPLUS].q_s;
    assign c_s      = {fin_s[WIDTH-1:0], fin_s[BW-2]};
    assign sum_s    = fin_s[3*WIDTH-1:2*WIDTH] ^ c_s[WIDTH-1:0];
    assign unused_s = ^fin_s[2*WIDTH-1:WIDTH];

    // Output register: loads on adv when the final stage holds a valid result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= {WIDTH{1'b0}};
            out_cout  <= 1'b0;
`ifdef PREFIX_ADDER_PIPE_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else if (adv_s) begin
            out_valid <= fin_s[BW-1];
            if (fin_s[BW-1]) begin
                out_sum  <= sum_s;
                out_cout <= c_s[WIDTH];
`ifdef PREFIX_ADDER_PIPE_OVF_EN
                out_ovf  <= c_s[WIDTH-1] ^ c_s[WIDTH];
`endif
            end
        end
    end
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe: directed table at WIDTH=8/STAGES=1 plus
// randomized sweeps over several WIDTH/STAGES configurations against an arithmetic model.
module tb_prefix_adder_pipe;
    localparam int W    = 8;
    localparam int S    = 1;
    localparam int LAT  = S + 2;
    localparam int NV   = 9;
    localparam int NCFG = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int sw_done = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int cfg_w(int k);
        case (k)
            0, 1:    return 5;
            2:       return 8;
            3:       return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_s(int k);
        case (k)
            0:       return 0;
            1:       return 3;
            2:       return 2;
            3:       return 3;
            4:       return 4;
            default: return 6;
        endcase
    endfunction

    logic         rst, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout;
    logic [W-1:0] in_a, in_b, out_sum;
`ifdef PREFIX_ADDER_PIPE_OVF_EN
    logic         out_ovf;
`endif

    prefix_adder_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
`ifdef PREFIX_ADDER_PIPE_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t       vecs [NV];
    logic [7:0] got_q [$];

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
    endtask

    initial begin
        vecs[0] = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[5] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[8] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_sum", out_sum, 8'h00);
        chk("reset_out_cout", out_cout, 1'b0);
`ifdef PREFIX_ADDER_PIPE_OVF_EN
        chk("reset_out_ovf", out_ovf, 1'b0);
`endif

        // Streamed table, one op per cycle, results appear LAT cycles later.
        for (int t = 0; t < NV + LAT + 1; t++) begin
            @(posedge clk); #1;
            if (t < NV) drive(vecs[t].a, vecs[t].b, vecs[t].cin, vecs[t].sub);
            else in_valid = 1'b0;
            @(negedge clk);
            if (t >= LAT && t - LAT < NV) begin
                chk($sformatf("tbl%0d_valid", t - LAT), out_valid, 1'b1);
                chk($sformatf("tbl%0d_sum", t - LAT), out_sum, vecs[t-LAT].sum);
                chk($sformatf("tbl%0d_cout", t - LAT), out_cout, vecs[t-LAT].cout);
`ifdef PREFIX_ADDER_PIPE_OVF_EN
                chk($sformatf("tbl%0d_ovf", t - LAT), out_ovf, vecs[t-LAT].ovf);
`endif
            end else begin
                chk($sformatf("tbl_idle%0d_valid", t), out_valid, 1'b0);
            end
        end

        // Backpressure: three ops in, consumer stalls for five cycles.
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            drive(8'h0A + 8'(t), 8'h03, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        drive(8'hAA, 8'h55, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_in_ready", k), in_ready, 1'b0);
            chk($sformatf("bp%0d_out_valid", k), out_valid, 1'b1);
            chk($sformatf("bp%0d_hold_sum", k), out_sum, 8'h0D);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) got_q.push_back(out_sum);
            @(posedge clk); #1;
        end
        chk("bp_count", got_q.size(), 3);
        for (int k = 0; k < 3 && k < got_q.size(); k++)
            chk($sformatf("bp_order%0d", k), got_q[k], 8'h0D + 8'(k));

        // Mid-flight reset: nothing in flight or offered with rst may emerge.
        drive(8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(8'h33, 8'h44, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rst_quiet%0d", k), out_valid, 1'b0);
            @(posedge clk); #1;
        end
        drive(8'h21, 8'h12, 1'b1, 1'b0);
        for (int t = 0; t <= LAT + 1; t++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid_t%0d", t), out_valid, (t == LAT));
            if (t == LAT) chk("post_rst_sum", {out_cout, out_sum}, 9'h034);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end

        for (int k = 0; k < 50000 && sw_done < NCFG; k++) @(posedge clk);
        chk("sweep_complete", sw_done, NCFG);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    for (genvar k = 0; k < NCFG; k++) begin : g_sw
        localparam int SW = cfg_w(k);
        localparam int SS = cfg_s(k);
        localparam int SL = SS + 2;

        logic          sr, siv, sir, sov, sor, scin, ssub, scout;
        logic [SW-1:0] sa, sb, ssum;
`ifdef PREFIX_ADDER_PIPE_OVF_EN
        logic          sovf;
        logic          ovf_q [$];
`endif
        logic [SW:0]   exp_q [$];
        int            acc_q [$];

        prefix_adder_pipe #(.WIDTH(SW), .STAGES(SS)) u_sw (
            .clk(clk), .rst(sr),
            .in_valid(siv), .in_ready(sir),
            .in_a(sa), .in_b(sb), .in_cin(scin), .in_sub(ssub),
            .out_valid(sov), .out_ready(sor),
            .out_sum(ssum), .out_cout(scout)
`ifdef PREFIX_ADDER_PIPE_OVF_EN
            , .out_ovf(sovf)
`endif
        );

        function automatic logic [SW:0] ref_sum(logic [SW-1:0] x, logic [SW-1:0] y, logic ci, logic su);
            logic [SW-1:0] yb;
            yb = su ? ~y : y;
            return {1'b0, x} + {1'b0, yb} + (SW+1)'(ci ^ su);
        endfunction

        function automatic logic ref_ovf(logic [SW-1:0] x, logic [SW-1:0] y, logic ci, logic su);
            logic [SW-1:0] yb;
            logic [SW+1:0] t;
            yb = su ? ~y : y;
            t  = {{2{x[SW-1]}}, x} + {{2{yb[SW-1]}}, yb} + (SW+2)'(ci ^ su);
            return t[SW] ^ t[SW-1];
        endfunction

        task automatic observe(input int t);
            if (sov && sor) begin
                chk($sformatf("sw%0d_nonempty", k), exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    chk($sformatf("sw%0d_result", k), {scout, ssum}, exp_q.pop_front());
`ifdef PREFIX_ADDER_PIPE_OVF_EN
                    chk($sformatf("sw%0d_ovf", k), sovf, ovf_q.pop_front());
`endif
                    if (t < 100) chk($sformatf("sw%0d_latency", k), t - acc_q[0], SL);
                    void'(acc_q.pop_front());
                end
            end
        endtask

        initial begin
            sr = 1'b1; siv = 1'b0; sor = 1'b1; sa = '0; sb = '0; scin = 1'b0; ssub = 1'b0;
            repeat (3) @(posedge clk);
            #1 sr = 1'b0;
            for (int t = 0; t < 2500; t++) begin
                siv  = ($urandom_range(0, 3) != 0);
                sor  = (t < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
                sa   = SW'({$urandom(), $urandom()});
                sb   = SW'({$urandom(), $urandom()});
                scin = 1'($urandom_range(0, 1));
                ssub = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) begin
                    sa = '1; sb = '0; scin = 1'b1; ssub = 1'b0;
                end
                @(negedge clk);
                observe(t);
                if (siv && sir) begin
                    exp_q.push_back(ref_sum(sa, sb, scin, ssub));
                    acc_q.push_back(t);
`ifdef PREFIX_ADDER_PIPE_OVF_EN
                    ovf_q.push_back(ref_ovf(sa, sb, scin, ssub));
`endif
                end
                @(posedge clk); #1;
            end
            siv = 1'b0;
            sor = 1'b1;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                observe(1000000);
                @(posedge clk); #1;
            end
            chk($sformatf("sw%0d_drained", k), exp_q.size(), 0);
            sw_done++;
        end
    end
endmodule
